// File: rtl/ppm_slot_modulator_if.sv
// ---------------------------------------------------------------------------
// ppm_slot_modulator_if
// Symbol/control bundle between the transmitter sequencer and the 4-PPM slot
// modulator.
//   start      : frame start strobe (single cycle)
//   abort      : synchronous frame abort
//   sym_in     : 2-bit symbol from the serializer
//   ppm_out    : registered PPM pulse to the laser/LED driver
//   busy       : registered, high while a frame is in progress
//   frame_done : registered single-cycle pulse at normal frame end
// master = sequencer side, slave = modulator side.
// ---------------------------------------------------------------------------
interface ppm_slot_modulator_if;
   logic       start;
   logic       abort;
   logic [1:0] sym_in;
   logic       ppm_out;
   logic       busy;
   logic       frame_done;

   modport master (output start, abort, sym_in,
                   input  ppm_out, busy, frame_done);
   modport slave  (input  start, abort, sym_in,
                   output ppm_out, busy, frame_done);
endinterface

// File: rtl/ppm_slot_modulator.sv
// ---------------------------------------------------------------------------
// ppm_slot_modulator
// Converts a frame of NUM_SYM 2-bit symbols into 4-PPM pulses: each symbol
// period of SYM_LEN cycles is split into four slots and one PULSE_W-wide pulse
// is placed at the start of the slot selected by the symbol (binary mapping).
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : ppm_slot_modulator_if.slave (start/abort/sym_in in,
//           ppm_out/busy/frame_done out, all outputs registered)
// ---------------------------------------------------------------------------
module ppm_slot_modulator #(
   parameter int SYM_LEN = 128,
   parameter int PULSE_W = 8,
   parameter int LEAD    = 2,
   parameter int NUM_SYM = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ppm_slot_modulator_if.slave   bus
);

   localparam int CW = $clog2(SYM_LEN);
   localparam int IW = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;

   localparam logic [CW-1:0] LEAD_LAST = CW'(LEAD - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(SYM_LEN - 1);
   localparam logic [CW-1:0] PW_M1     = CW'(PULSE_W - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_SYM - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SYM} state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [IW-1:0]   r_sym_idx, w_idx_nxt;
   logic [1:0]      r_sym, w_sym_nxt;
   logic            r_ppm, w_ppm_nxt;
   logic            r_busy, w_busy_nxt;
   logic            r_done, w_done_nxt;

   logic            w_lead_end, w_period_end, w_last_sym, w_in_pulse;
   logic [CW-1:0]   w_base, w_end;

   assign w_lead_end   = (r_cnt == LEAD_LAST);
   assign w_period_end = (r_cnt == CNT_LAST);
   assign w_last_sym   = (r_sym_idx == IDX_LAST);
   // slot base = sym * SYM_LEN/4; SYM_LEN is a power of two so this is a shift
   assign w_base       = {r_sym, {(CW-2){1'b0}}};
   // PULSE_W <= SLOT_LEN keeps w_end inside the period, no wrap possible
   assign w_end        = w_base + PW_M1;
   assign w_in_pulse   = (r_cnt >= w_base) && (r_cnt <= w_end);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (bus.start && !bus.abort)       w_state_nxt = S_WAIT;
         S_WAIT: if (bus.abort)                     w_state_nxt = S_IDLE;
                 else if (w_lead_end)               w_state_nxt = S_SYM;
         S_SYM:  if (bus.abort)                     w_state_nxt = S_IDLE;
                 else if (w_period_end && w_last_sym) w_state_nxt = S_IDLE;
         default:                                   w_state_nxt = S_IDLE;
      endcase
   end

   // output / datapath next values
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_idx_nxt  = r_sym_idx;
      w_sym_nxt  = r_sym;
      w_ppm_nxt  = 1'b0;
      w_busy_nxt = r_busy;
      w_done_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            // abort beats a simultaneous start
            if (bus.start && !bus.abort) begin
               w_cnt_nxt  = '0;
               w_busy_nxt = 1'b1;
            end
         end
         S_WAIT: begin
            if (bus.abort) begin
               w_cnt_nxt  = '0;
               w_busy_nxt = 1'b0;
            end else if (w_lead_end) begin
               w_sym_nxt = bus.sym_in;
               w_cnt_nxt = '0;
               w_idx_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_SYM: begin
            if (bus.abort) begin
               w_cnt_nxt  = '0;
               w_busy_nxt = 1'b0;
            end else begin
               // pulse is registered: visible one cycle after cnt hits base
               w_ppm_nxt = w_in_pulse;
               if (w_period_end) begin
                  w_cnt_nxt = '0;
                  if (w_last_sym) begin
                     w_busy_nxt = 1'b0;
                     w_done_nxt = 1'b1;
                  end else begin
                     w_idx_nxt = r_sym_idx + 1'b1;
                     w_sym_nxt = bus.sym_in;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_cnt_nxt  = '0;
            w_busy_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_sym_idx <= '0;
         r_sym     <= '0;
         r_ppm     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_sym_idx <= w_idx_nxt;
         r_sym     <= w_sym_nxt;
         r_ppm     <= w_ppm_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign bus.ppm_out    = r_ppm;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_done;

endmodule

// File: tb/tb_ppm_slot_modulator.sv
// ---------------------------------------------------------------------------
// tb_ppm_slot_modulator
// Directed bench for ppm_slot_modulator. Two instances share stimulus:
// u_dut (PULSE_W=8) and u_dut_w32 (PULSE_W=32). Edge E0 is the edge that
// accepts start; outputs are sampled 1 time unit after each rising edge.
// Expected pulse window for symbol k with value s (first sample at E2):
//   edges 3+128k+32s .. 3+128k+32s+PULSE_W-1.
// ---------------------------------------------------------------------------
module tb_ppm_slot_modulator;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   ppm_slot_modulator_if if1 ();
   ppm_slot_modulator_if if2 ();

   assign if2.start  = if1.start;
   assign if2.abort  = if1.abort;
   assign if2.sym_in = if1.sym_in;

   ppm_slot_modulator u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   ppm_slot_modulator #(.PULSE_W(32)) u_dut_w32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " ppm"},   if1.ppm_out,    0);
      chk({tag, " busy"},  if1.busy,       0);
      chk({tag, " done"},  if1.frame_done, 0);
      chk({tag, " ppm32"}, if2.ppm_out,    0);
   endtask

   // Runs one frame from E0 to E<last_e>, checking every edge.
   // syms[2k+:2] is symbol k; extra_start re-pulses start mid-frame
   // (-1 = none); abort_e is the edge that samples abort (0 = none).
   task automatic run_frame(input logic [7:0] syms, input int last_e,
                            input int extra_start, input int abort_e);
      int   rise1, rise2, lo;
      logic p1, p2, ab, e_b, e_d, e_p1, e_p2;
      rise1 = 0; rise2 = 0; p1 = 1'b0; p2 = 1'b0;
      for (int e = 0; e <= last_e; e++) begin
         if1.start  = (e == 0) || (e == extra_start);
         if1.abort  = (abort_e > 0) && (e == abort_e);
         if1.sym_in = 2'($urandom);
         for (int k = 0; k < 4; k++)
            if (e == 2 + 128*k) if1.sym_in = syms[2*k +: 2];
         step();
         ab   = (abort_e > 0) && (e >= abort_e);
         e_b  = !ab && (e < 514);
         e_d  = !ab && (e == 514);
         e_p1 = 1'b0;
         e_p2 = 1'b0;
         for (int k = 0; k < 4; k++) begin
            lo = 3 + 128*k + 32*int'(syms[2*k +: 2]);
            if (!ab && e >= lo && e <= lo + 7)  e_p1 = 1'b1;
            if (!ab && e >= lo && e <= lo + 31) e_p2 = 1'b1;
         end
         chk($sformatf("ppm8 E%0d", e),  if1.ppm_out,    e_p1);
         chk($sformatf("ppm32 E%0d", e), if2.ppm_out,    e_p2);
         chk($sformatf("busy E%0d", e),  if1.busy,       e_b);
         chk($sformatf("done E%0d", e),  if1.frame_done, e_d);
         if (if1.ppm_out && !p1) rise1++;
         if (if2.ppm_out && !p2) rise2++;
         p1 = if1.ppm_out;
         p2 = if2.ppm_out;
      end
      if1.start = 1'b0;
      if1.abort = 1'b0;
      if (abort_e == 0 && last_e >= 514) begin
         chk("pulses8", rise1, 4);
         chk("pulses32", rise2, 4);
      end
   endtask

   initial begin
      if1.start  = 1'b0;
      if1.abort  = 1'b0;
      if1.sym_in = 2'b00;
      repeat (3) step();
      chk_idle("reset");
      rst_n = 1'b1;
      step();
      chk_idle("post_reset");

      // abort+start together in IDLE: abort wins
      if1.start = 1'b1; if1.abort = 1'b1;
      step();
      if1.start = 1'b0; if1.abort = 1'b0;
      chk_idle("idle_abort_start");
      step();
      chk_idle("idle_abort_start+1");

      // sym 10 held for the whole frame
      run_frame(8'b10101010, 514, -1, 0);
      repeat (3) step();
      chk_idle("after_frame1");

      // symbols 00,01,10,11 with a stray start at E100
      run_frame(8'b11100100, 514, 100, 0);
      step();
      chk_idle("after_frame2");

      // all 11 (PULSE_W=32 fills to the period end), then back-to-back frame
      run_frame(8'b11111111, 514, -1, 0);
      run_frame(8'b00011011, 514, -1, 0);
      step();
      chk_idle("after_b2b");

      // abort sampled at E201 mid-pulse, restart sampled at E205
      run_frame(8'b00001000, 204, -1, 201);
      run_frame(8'b01010101, 514, -1, 0);
      step();

      // asynchronous reset at E70 inside a pulse
      run_frame(8'b10101010, 70, -1, 0);
      rst_n = 1'b0;
      #1;
      chk_idle("async_reset");
      step();
      rst_n = 1'b1;
      if1.start = 1'b0;
      repeat (5) step();
      chk_idle("idle_after_reset");

      // fresh frame after the reset
      run_frame(8'b00100111, 514, -1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ppm_slot_modulator.md
Name: ppm_slot_modulator

Overview:
- Downstream consumer of the 2-bit symbol serializer in the PPM transmitter.
- Converts each 2-bit symbol into one 4-PPM optical pulse: one pulse in one of four equal slots of a symbol period.
- Runs a fixed-length frame of NUM_SYM symbols after a start strobe, then signals frame completion.
- Its output drives the laser/LED driver.

Parameters:
- SYM_LEN, 128: clock cycles per symbol period. Power of two, at least 8.
- PULSE_W, 8: pulse width in cycles. Range 1..SYM_LEN/4.
- LEAD, 2: cycles from start acceptance to the first symbol sample. At least 1.
- NUM_SYM, 4: symbols per frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start strobe, single cycle; same strobe that loads the serializer
- abort  in  1  synchronous frame abort
- sym_in  in  2  current symbol from the serializer
- ppm_out  out  1  registered PPM pulse output
- busy  out  1  registered; high while a frame is in progress
- frame_done  out  1  registered single-cycle pulse at normal frame end

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; cnt, sym_idx, sym_reg all 0.
  - ppm_out=0, busy=0, frame_done=0.
- Widths:
  - cnt is log2(SYM_LEN) bits.
  - sym_idx is log2(NUM_SYM) bits, minimum 1.
  - SLOT_LEN=SYM_LEN/4.
  - Slot base = sym_reg*SLOT_LEN. Binary mapping: 00→slot0, 01→slot1, 10→slot2, 11→slot3.
- States: IDLE, WAIT, SYM.
- IDLE:
  - start=1 at edge E0 → WAIT, cnt=0, busy=1.
  - start is ignored in all other states.
- WAIT:
  - cnt increments each cycle.
  - At the edge where cnt==LEAD-1: sym_reg<=sym_in, cnt<=0, sym_idx<=0, go to SYM.
  - With LEAD=2, the first sample is at E2.
- SYM:
  - cnt increments each cycle.
  - At cnt==SYM_LEN-1: cnt<=0.
    - If sym_idx==NUM_SYM-1: go to IDLE, busy<=0, frame_done<=1 for exactly one cycle.
    - Otherwise: sym_idx+1, sym_reg<=sym_in (next symbol sampled at the period boundary).
- ppm_out:
  - Next-state value is 1 iff state==SYM and base ≤ cnt ≤ base+PULSE_W-1.
  - Therefore the pulse appears one cycle after cnt reaches base and lasts exactly PULSE_W cycles.
  - Never high in IDLE or WAIT.
- Symbol timing: symbol k (k=0..NUM_SYM-1) period occupies edges E(LEAD+k*SYM_LEN) through E(LEAD+(k+1)*SYM_LEN).
- abort:
  - High in WAIT or SYM: next edge forces IDLE, cnt=0, ppm_out=0, busy=0. No frame_done.
  - abort in IDLE has no effect.
  - abort and start high together in IDLE: abort wins, stay IDLE.
- Frame end and restart: start high in the cycle after the IDLE re-entry edge is accepted normally. Back-to-back frames are allowed with a 1-cycle gap minimum.
- sym_in is only sampled at the specified edges; changes between samples have no effect.
- Reset asserted mid-frame returns to the reset values immediately. No frame_done.

Test Plan:
- Reset → all outputs 0.
  - start pulse at E0, sym_in=2'b10 held → ppm_out high after E67 through E74 (cycles 67..74), low otherwise in symbol 0.
  - busy high from E0 until E514.
  - frame_done high only in the cycle after E514.
- Symbols 00,01,10,11 presented at the sample edges (E2, E130, E258, E386) → pulses start at E3, E163, E323, E483, each 8 cycles wide.
  - Exactly 4 pulses per frame.
- start during SYM (e.g. at E100) → ignored: frame timing unchanged, single frame_done at E514.
- abort at E200 → ppm_out=0 and busy=0 after E201. No frame_done. A new start at E205 begins a fresh frame with its first sample at E207.
- rst_n low at E70 during a symbol-2 pulse → ppm_out, busy, frame_done drop to 0 asynchronously. Stays IDLE after release until the next start.
- PULSE_W=32, SYM_LEN=128, sym=11 → pulse covers cycles 97..128 (cnt 96..127) with no spill into the next symbol.
  - Back-to-back start one cycle after frame_done → second frame's first sample lands LEAD edges after its start edge.
